// File: rtl/multiplier.sv
// Sequential unsigned N x N shift-add multiplier with a start/finish handshake.
// It retires one multiplier bit per clock and also shows the product as packed BCD.
module multiplier #(
  parameter int N = 4,
  localparam int W = 2 * N,
  localparam int D = (2 * N) / 3 + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  input  logic           start,
  output logic [W-1:0]   out,
  output logic           finish,
  output logic [4*D-1:0] bcd,
  output logic [1:0]     state_o
);

  // Handshake: start is a level request, taken only in IDLE. finish stays high
  // for the whole of DONE. DONE is left only once start drops, which gives
  // exactly one product per start assertion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(N + 1);

  state_t          state_q  = IDLE;
  logic [W-1:0]    a_q      = '0;
  logic [N-1:0]    b_q      = '0;
  logic [W-1:0]    acc_q    = '0;
  logic [CW-1:0]   cnt_q    = '0;
  logic [W-1:0]    out_q    = '0;
  logic            finish_q = 1'b0;
  logic [W-1:0]    acc_d;
  logic [4*D-1:0]  bcd_d;

  assign acc_d = b_q[0] ? (acc_q + a_q) : acc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= W'(a_in);
            b_q     <= b_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          // The last partial add is folded straight into out.
          if (cnt_q == CW'(N - 1)) begin
            out_q    <= acc_d;
            finish_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (!start) begin
            finish_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          finish_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Double-dabble on the registered product: add 3 to any digit >= 5 before each shift.
  always_comb begin
    bcd_d = '0;
    for (int i = W - 1; i >= 0; i--) begin
      for (int d = 0; d < D; d++) begin
        if (bcd_d[4*d +: 4] >= 4'd5) begin
          bcd_d[4*d +: 4] = bcd_d[4*d +: 4] + 4'd3;
        end
      end
      bcd_d = {bcd_d[4*D-2:0], out_q[i]};
    end
  end

  assign out     = out_q;
  assign finish  = finish_q;
  assign bcd     = bcd_d;
  assign state_o = state_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for multiplier: an N=5 instance carries the main scenarios,
// and an N=4 instance checks the narrower build and its 12-bit BCD.
module tb_multiplier;

  localparam int N5 = 5;
  localparam int W5 = 2 * N5;
  localparam int D5 = (2 * N5) / 3 + 1;
  localparam int N4 = 4;
  localparam int W4 = 2 * N4;
  localparam int D4 = (2 * N4) / 3 + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [N5-1:0]   a5 = '0;
  logic [N5-1:0]   b5 = '0;
  logic            start5 = 1'b0;
  logic [W5-1:0]   out5;
  logic            finish5;
  logic [4*D5-1:0] bcd5;
  logic [1:0]      state5;

  logic [N4-1:0]   a4 = '0;
  logic [N4-1:0]   b4 = '0;
  logic            start4 = 1'b0;
  logic [W4-1:0]   out4;
  logic            finish4;
  logic [4*D4-1:0] bcd4;
  logic [1:0]      state4;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  multiplier #(.N(N5)) dut5 (
    .clock(clk), .reset(rst), .a_in(a5), .b_in(b5), .start(start5),
    .out(out5), .finish(finish5), .bcd(bcd5), .state_o(state5)
  );

  multiplier #(.N(N4)) dut4 (
    .clock(clk), .reset(rst), .a_in(a4), .b_in(b4), .start(start4),
    .out(out4), .finish(finish4), .bcd(bcd4), .state_o(state4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- drivers ----------------
  // Runs one N=5 product: start is first sampled at the edge after the call,
  // operands are scrambled during CALC, and start is held for `hold` cycles
  // after finish before being dropped.
  task automatic run_mul5(input logic [N5-1:0] a, input logic [N5-1:0] b,
                          input logic [31:0] exp_out, input logic [31:0] exp_bcd,
                          input int hold);
    logic [W5-1:0] prev_out;
    logic [31:0]   want;
    int cyc;
    a5 = a;
    b5 = b;
    start5 = 1'b1;
    exp_q.push_back(exp_out);
    prev_out = out5;
    tick;
    cyc = 1;
    check("state_calc", 32'(state5), 32'(S_CALC));
    a5 = ~a;
    b5 = b ^ 5'h15;
    while (!finish5 && cyc < 20) begin
      check("out_hold_calc", 32'(out5), 32'(prev_out));
      tick;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd6);
    want = exp_q.pop_front();
    check("out", 32'(out5), want);
    check("bcd", 32'(bcd5), exp_bcd);
    check("state_done", 32'(state5), 32'(S_DONE));
    for (int i = 0; i < hold; i++) begin
      tick;
      check("finish_held", 32'(finish5), 32'd1);
      check("out_held", 32'(out5), want);
    end
    start5 = 1'b0;
    tick;
    check("finish_drop", 32'(finish5), 32'd0);
    check("state_idle", 32'(state5), 32'(S_IDLE));
    check("out_after_done", 32'(out5), want);
  endtask

  task automatic run_mul4(input logic [N4-1:0] a, input logic [N4-1:0] b,
                          input logic [31:0] exp_out, input logic [31:0] exp_bcd);
    int cyc;
    a4 = a;
    b4 = b;
    start4 = 1'b1;
    tick;
    cyc = 1;
    a4 = '0;
    b4 = '0;
    while (!finish4 && cyc < 20) begin
      tick;
      cyc++;
    end
    check("n4_latency", 32'(cyc), 32'd5);
    check("n4_out", 32'(out4), exp_out);
    check("n4_bcd", 32'(bcd4), exp_bcd);
    start4 = 1'b0;
    tick;
    check("n4_finish_drop", 32'(finish4), 32'd0);
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int saw_finish;
    #1;
    check("powerup_out", 32'(out5), 32'd0);
    check("powerup_state", 32'(state5), 32'(S_IDLE));

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start5 = 1'b1;
    a5 = 5'd3;
    b5 = 5'd3;
    tick;
    tick;
    rst = 1'b0;
    start5 = 1'b0;
    check("rst_out", 32'(out5), 32'd0);
    check("rst_bcd", 32'(bcd5), 32'h0000);
    check("rst_finish", 32'(finish5), 32'd0);
    check("rst_state", 32'(state5), 32'(S_IDLE));
    check("rst_n4_out", 32'(out4), 32'd0);

    // 26 x 30, start held 10 cycles in total (6 to finish + 4 more).
    run_mul5(5'd26, 5'd30, 32'd780, 32'h0780, 4);
    tick;
    run_mul5(5'd13, 5'd13, 32'd169, 32'h0169, 0);
    run_mul5(5'd31, 5'd31, 32'd961, 32'h0961, 1);

    // Reset lands on the 3rd CALC cycle of 20 x 20.
    a5 = 5'd20;
    b5 = 5'd20;
    start5 = 1'b1;
    tick;
    tick;
    tick;
    rst = 1'b1;
    start5 = 1'b0;
    tick;
    rst = 1'b0;
    check("midrst_out", 32'(out5), 32'd0);
    check("midrst_bcd", 32'(bcd5), 32'h0000);
    check("midrst_state", 32'(state5), 32'(S_IDLE));
    saw_finish = 0;
    for (int i = 0; i < 8; i++) begin
      if (finish5) saw_finish = 1;
      tick;
    end
    check("midrst_no_finish", 32'(saw_finish), 32'd0);

    run_mul5(5'd20, 5'd20, 32'd400, 32'h0400, 0);
    run_mul5(5'd0, 5'd17, 32'd0, 32'h0000, 0);
    run_mul5(5'd1, 5'd31, 32'd31, 32'h0031, 0);

    run_mul4(4'd15, 4'd15, 32'd225, 32'h225);
    run_mul4(4'd9, 4'd7, 32'd63, 32'h063);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
Sequential unsigned N×N shift-add multiplier with a start/finish handshake.
- Latches both operands when start is accepted and iterates one multiplier bit per clock.
- Presents the 2N-bit product in binary and as packed BCD for display logic.
- Sits between operand registers/switches and a result/7-segment display path.

Parameters:
N, 4, operand width in bits (≥2); product width 2N; BCD digit count D = floor(2N/3)+1 (integer division).

Ports:
clock  input  1  rising-edge clock, sole clock domain
reset  input  1  synchronous, active-high reset
a_in  input  N  multiplicand, unsigned, sampled only when start is accepted
b_in  input  N  multiplier, unsigned, sampled only when start is accepted
start  input  1  level request; accepted only in IDLE
out  output  2N  registered unsigned product a×b
finish  output  1  high while in DONE (result valid)
bcd  output  4D  packed BCD of out, digit 0 (ones) in bits [3:0], unused upper digits zero

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on rising clock.
- Reset state: IDLE; out=0; finish=0; bcd=0; internal accumulator, shifted operand copies and bit counter all 0.
- Power-up: all registers initialise to their reset values at declaration, so the block works even if reset is never pulsed.
- State machine: IDLE, CALC, DONE.
- IDLE: if start=1, load A=zero-extend(a_in) to 2N bits, B=b_in, acc=0, count=0, go to CALC. Otherwise stay in IDLE.
- CALC, each cycle:
  - if B[0], acc ← acc + A (mod 2^2N, cannot overflow for unsigned N×N);
  - A ← A<<1; B ← B>>1; count ← count+1;
  - after the N-th CALC cycle, go to DONE and load out with the final acc, including the last partial add.
- DONE: finish=1. Stay in DONE while start=1; return to IDLE when start=0. Exactly one multiplication per start assertion, even if start is held high.
- Latency:
  - start sampled high in IDLE at edge k → CALC on edges k+1..k+N → out valid and finish=1 after edge k+N.
  - Total N+1 clocks, i.e. 6 cycles for N=5.
- out holds its value from DONE through IDLE and the next CALC; it changes only on entry to DONE or on reset.
- bcd: combinational binary-to-BCD (double-dabble: add 3 to any digit ≥5 before each shift) of the out register. It is therefore stable whenever out is, and valid together with finish.
- Operand changes during CALC/DONE are ignored.
- start=1 with reset=1 in the same cycle: reset wins.
- Reset mid-CALC: abort, clear out to 0, no finish pulse.
- Zero operands: product 0, same latency; no early termination.

Test Plan:
- N=5, reset pulse -> out=0, bcd=0x0000, finish=0, IDLE.
- N=5, a_in=26, b_in=30, start held high 10 cycles -> finish=1 six clocks after first sampled start; out=780 (0x30C); bcd=0x0780. finish stays 1 while start=1 and drops the cycle after start=0; out remains 780.
- Same run, then a_in=13, b_in=13, start 0 for 2 cycles then high -> out=169, bcd=0x0169. out shows 780 until the new DONE.
- N=5, a_in=31, b_in=31 -> out=961, bcd=0x0961; a_in=0, b_in=17 -> out=0, bcd=0x0000 with same latency.
- Assert reset for one cycle in the 3rd CALC cycle of 20×20 -> out=0, finish never rises. Afterwards start with 20×20 -> out=400, bcd=0x0400.
- Change a_in/b_in during CALC -> result reflects operands latched at start. N=4 build: 15×15=225, bcd width 12 bits = 0x225.
